// File: rtl/fake_mem_sched_pkg.sv
// Shared types and defaults for the fake-memory AXI4 handshake scheduler.
package fake_mem_sched_pkg;

  localparam int unsigned DEF_LEN_WIDTH = 8;
  localparam int unsigned DEF_LAT_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AR     = 3'd1,
    S_R_LAT  = 3'd2,
    S_R_DATA = 3'd3,
    S_AW     = 3'd4,
    S_W_DATA = 3'd5,
    S_W_LAT  = 3'd6,
    S_B      = 3'd7
  } sched_state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/fake_mem_lat_timer.sv
// Loadable down-counter; done is high while the count sits at 1, i.e. in the
// last idle cycle before the next phase may start.
module fake_mem_lat_timer
  import fake_mem_sched_pkg::*;
#(
  parameter int unsigned LAT_WIDTH = DEF_LAT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LAT_WIDTH-1:0] load_val,
  output logic                 done
);

  logic [LAT_WIDTH-1:0] cnt_q;
  logic [LAT_WIDTH-1:0] cnt_d;

  // next count: load wins, otherwise decrement until zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {LAT_WIDTH{1'b0}}) begin
      cnt_d = cnt_q - LAT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {LAT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAT_WIDTH'(1));

endmodule

// File: rtl/fake_mem_axi_scheduler.sv
// One-transaction-in-flight AXI4 handshake gate with round-robin read/write
// arbitration and programmable read/write latency insertion.
module fake_mem_axi_scheduler
  import fake_mem_sched_pkg::*;
#(
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned LAT_WIDTH  = DEF_LAT_WIDTH,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned WR_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  input  logic [LEN_WIDTH-1:0] s_arlen,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  input  logic                 m_rlast,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [LEN_WIDTH-1:0] s_awlen,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  input  logic                 s_wlast,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  output logic                 busy,
  output logic                 proto_err
);

  sched_state_e         state_q, state_d;
  grant_e               grant_q, grant_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic                 perr_q, perr_d;
  logic                 lat_load;
  logic [LAT_WIDTH-1:0] lat_val;
  logic                 lat_done;

  fake_mem_lat_timer #(.LAT_WIDTH(LAT_WIDTH)) u_lat_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lat_load),
    .load_val (lat_val),
    .done     (lat_done)
  );

  // next-state, counters and handshake gating for the granted channel only
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    perr_d    = perr_q;
    lat_load  = 1'b0;
    lat_val   = {LAT_WIDTH{1'b0}};
    m_arvalid = 1'b0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    s_awready = 1'b0;
    m_wvalid  = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    m_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_arvalid && s_awvalid) begin
          if (grant_q == GRANT_WRITE) begin
            state_d = S_AR;
            grant_d = GRANT_READ;
          end else begin
            state_d = S_AW;
            grant_d = GRANT_WRITE;
          end
        end else if (s_arvalid) begin
          state_d = S_AR;
          grant_d = GRANT_READ;
        end else if (s_awvalid) begin
          state_d = S_AW;
          grant_d = GRANT_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        m_arvalid = s_arvalid;
        s_arready = m_arready;
        if (s_arvalid && m_arready) begin
          beat_d = s_arlen;
          if (RD_LATENCY == 0) begin
            state_d = S_R_DATA;
          end else begin
            lat_load = 1'b1;
            lat_val  = LAT_WIDTH'(RD_LATENCY);
            state_d  = S_R_LAT;
          end
        end else begin
          state_d = S_AR;
        end
      end
      S_R_LAT: begin
        if (lat_done) begin
          state_d = S_R_DATA;
        end else begin
          state_d = S_R_LAT;
        end
      end
      S_R_DATA: begin
        s_rvalid = m_rvalid;
        m_rready = s_rready;
        if (m_rvalid && s_rready) begin
          // the beat count, not the last flag, decides when the burst ends
          if (m_rlast != (beat_q == {LEN_WIDTH{1'b0}})) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
          if (beat_q == {LEN_WIDTH{1'b0}}) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q - LEN_WIDTH'(1);
          end
        end else begin
          state_d = S_R_DATA;
        end
      end
      S_AW: begin
        m_awvalid = s_awvalid;
        s_awready = m_awready;
        if (s_awvalid && m_awready) begin
          beat_d  = s_awlen;
          state_d = S_W_DATA;
        end else begin
          state_d = S_AW;
        end
      end
      S_W_DATA: begin
        m_wvalid = s_wvalid;
        s_wready = m_wready;
        if (s_wvalid && m_wready) begin
          if (s_wlast != (beat_q == {LEN_WIDTH{1'b0}})) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
          if (beat_q == {LEN_WIDTH{1'b0}}) begin
            if (WR_LATENCY == 0) begin
              state_d = S_B;
            end else begin
              lat_load = 1'b1;
              lat_val  = LAT_WIDTH'(WR_LATENCY);
              state_d  = S_W_LAT;
            end
          end else begin
            beat_d = beat_q - LEN_WIDTH'(1);
          end
        end else begin
          state_d = S_W_DATA;
        end
      end
      S_W_LAT: begin
        if (lat_done) begin
          state_d = S_B;
        end else begin
          state_d = S_W_LAT;
        end
      end
      S_B: begin
        s_bvalid = m_bvalid;
        m_bready = s_bready;
        if (m_bvalid && s_bready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_B;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // control registers; reset favours read on the first contested grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= GRANT_WRITE;
      beat_q  <= {LEN_WIDTH{1'b0}};
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      perr_q  <= perr_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign proto_err = perr_q;

endmodule

// File: tb/tb_fake_mem_axi_scheduler.sv
// Directed bench: a cycle table for read/write/protocol-error sequences, plus
// hand-written arbitration, backpressure and mid-burst reset sequences.
module tb_fake_mem_axi_scheduler;

  logic       clk;
  logic       rst_n;
  logic       s_arvalid, s_arready, m_arvalid, m_arready;
  logic [7:0] s_arlen, s_awlen;
  logic       s_rvalid, s_rready, m_rvalid, m_rready, m_rlast;
  logic       s_awvalid, s_awready, m_awvalid, m_awready;
  logic       s_wvalid, s_wready, s_wlast, m_wvalid, m_wready;
  logic       s_bvalid, s_bready, m_bvalid, m_bready;
  logic       busy, proto_err;

  int errors = 0;
  int checks = 0;

  fake_mem_axi_scheduler #(
    .LEN_WIDTH(8), .LAT_WIDTH(8), .RD_LATENCY(4), .WR_LATENCY(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arlen(s_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awlen(s_awlen),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs : s_arvalid m_arready | s_rready m_rvalid m_rlast | s_awvalid m_awready
  //          | s_wvalid s_wlast m_wready | s_bready m_bvalid
  // outputs: m_arvalid s_arready | s_rvalid m_rready | m_awvalid s_awready
  //          | m_wvalid s_wready | s_bvalid m_bready | busy proto_err
  typedef struct {
    logic [11:0] in;
    logic [7:0]  arlen;
    logic [7:0]  awlen;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [11:0] i, logic [7:0] al, logic [7:0] wl, logic [11:0] e);
    vec_t v;
    v.in = i; v.arlen = al; v.awlen = wl; v.exp = e;
    return v;
  endfunction

  function automatic logic [11:0] obs();
    return {m_arvalid, s_arready, s_rvalid, m_rready, m_awvalid, s_awready,
            m_wvalid, s_wready, s_bvalid, m_bready, busy, proto_err};
  endfunction

  task automatic drive(logic [11:0] i, logic [7:0] al, logic [7:0] wl);
    {s_arvalid, m_arready, s_rready, m_rvalid, m_rlast, s_awvalid, m_awready,
     s_wvalid, s_wlast, m_wready, s_bready, m_bvalid} = i;
    s_arlen = al;
    s_awlen = wl;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    drive(12'b0, 8'd0, 8'd0);
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int got[4];
  int n, hs;
  bit ar_done, aw_done, tog;

  initial begin
    // single read arlen=3 with RD_LATENCY=4; AW request parked meanwhile
    tbl.push_back(mk(12'b00_000_00_000_00, 8'd0, 8'd0, 12'b00_00_00_00_00_00));
    tbl.push_back(mk(12'b11_000_00_000_00, 8'd3, 8'd0, 12'b00_00_00_00_00_00));
    tbl.push_back(mk(12'b11_000_00_000_00, 8'd3, 8'd0, 12'b11_00_00_00_00_10));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(12'b00_110_11_000_00, 8'd0, 8'd0, 12'b00_00_00_00_00_10));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(12'b00_110_11_000_00, 8'd0, 8'd0, 12'b00_11_00_00_00_10));
    tbl.push_back(mk(12'b00_111_11_000_00, 8'd0, 8'd0, 12'b00_11_00_00_00_10));
    tbl.push_back(mk(12'b00_000_00_000_00, 8'd0, 8'd0, 12'b00_00_00_00_00_00));
    // single-beat write, WR_LATENCY=0: B forwarded the cycle after the W beat
    tbl.push_back(mk(12'b00_000_11_000_00, 8'd0, 8'd0, 12'b00_00_00_00_00_00));
    tbl.push_back(mk(12'b00_000_11_000_00, 8'd0, 8'd0, 12'b00_00_11_00_00_10));
    tbl.push_back(mk(12'b00_000_00_111_11, 8'd0, 8'd0, 12'b00_00_00_11_00_10));
    tbl.push_back(mk(12'b00_000_00_000_11, 8'd0, 8'd0, 12'b00_00_00_00_11_10));
    tbl.push_back(mk(12'b00_000_00_000_00, 8'd0, 8'd0, 12'b00_00_00_00_00_00));
    // arlen=1 with rlast on the first beat: sticky error, two beats consumed
    tbl.push_back(mk(12'b11_000_00_000_00, 8'd1, 8'd0, 12'b00_00_00_00_00_00));
    tbl.push_back(mk(12'b11_000_00_000_00, 8'd1, 8'd0, 12'b11_00_00_00_00_10));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(12'b00_110_00_000_00, 8'd0, 8'd0, 12'b00_00_00_00_00_10));
    tbl.push_back(mk(12'b00_111_00_000_00, 8'd0, 8'd0, 12'b00_11_00_00_00_10));
    tbl.push_back(mk(12'b00_111_00_000_00, 8'd0, 8'd0, 12'b00_11_00_00_00_11));
    tbl.push_back(mk(12'b00_000_00_000_00, 8'd0, 8'd0, 12'b00_00_00_00_00_01));

    reset_dut();
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].in, tbl[i].arlen, tbl[i].awlen);
      #2;
      chk($sformatf("vec[%0d]", i), 32'(obs()), 32'(tbl[i].exp));
    end

    // both channels permanently requesting: grants must alternate R,W,R,W
    reset_dut();
    n = 0;
    for (int k = 0; k < 4; k++) got[k] = -1;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      drive(12'b11_111_11_111_11, 8'd0, 8'd0);
      #2;
      if (m_arvalid && m_arready) begin
        got[n] = 0; n++;
      end else if (m_awvalid && m_awready) begin
        got[n] = 1; n++;
      end
    end
    chk("arb_count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("arb_grant[%0d]", k), 32'(got[k]), 32'(k % 2));
    chk("arb_proto_err", 32'(proto_err), 32'd0);

    // 8-beat read with s_rready toggling every cycle
    reset_dut();
    hs = 0; ar_done = 1'b0; tog = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      drive(12'b0, 8'd7, 8'd0);
      s_arvalid = !ar_done;
      m_arready = 1'b1;
      m_rvalid  = 1'b1;
      m_rlast   = (hs == 7);
      s_rready  = tog;
      tog = ~tog;
      #2;
      if (m_arvalid && s_arready) ar_done = 1'b1;
      if (s_rvalid) chk($sformatf("bp_mready[c%0d]", c), 32'(m_rready), 32'(s_rready));
      if (m_rvalid && m_rready) hs++;
      if (ar_done && !busy) break;
    end
    chk("bp_done", 32'(ar_done && !busy), 32'd1);
    chk("bp_beats", 32'(hs), 32'd8);
    chk("bp_proto_err", 32'(proto_err), 32'd0);

    // 4-beat write aborted by reset during beat 2, then a normal read
    reset_dut();
    hs = 0; aw_done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      drive(12'b00_000_00_101_11, 8'd0, 8'd3);
      s_awvalid = !aw_done;
      m_awready = 1'b1;
      s_wlast   = (hs == 3);
      #2;
      if (m_awvalid && s_awready) aw_done = 1'b1;
      if (m_wvalid && s_wready) hs++;
      if (hs == 1) break;
    end
    @(posedge clk);
    #2;
    chk("rst_mid_wready", 32'(s_wready), 32'd1);
    s_arvalid = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1; s_rready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'(obs()), 32'd0);
    #12;
    drive(12'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hs = 0; ar_done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      drive(12'b00_111_00_000_00, 8'd0, 8'd0);
      s_arvalid = !ar_done;
      m_arready = 1'b1;
      #2;
      if (m_arvalid && s_arready) ar_done = 1'b1;
      if (m_rvalid && m_rready) hs++;
      if (ar_done && !busy) break;
    end
    chk("post_rst_read_done", 32'(ar_done && !busy), 32'd1);
    chk("post_rst_read_beats", 32'(hs), 32'd1);
    chk("post_rst_proto_err", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
